// File: rtl/w_cdc_arbiter.sv
// Write-channel scheduler feeding the AW/W CDC FIFOs from two masters.
// Round-robin burst arbitration, B routing and an outstanding-burst cap.
module w_cdc_arbiter #(
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       m_awvalid,
  output logic [1:0]       m_awready,
  input  logic [1:0][3:0]  m_awid,
  input  logic [1:0][31:0] m_awaddr,
  input  logic [1:0][3:0]  m_awlen,
  input  logic [1:0][2:0]  m_awsize,
  input  logic [1:0][1:0]  m_awburst,
  input  logic [1:0]       m_wvalid,
  output logic [1:0]       m_wready,
  input  logic [1:0][31:0] m_wdata,
  input  logic [1:0][3:0]  m_wstrb,
  output logic [1:0]       m_bvalid,
  input  logic [1:0]       m_bready,
  output logic [3:0]       m_bid,
  output logic [1:0]       m_bresp,
  output logic             AW_wr_en,
  output logic [48:0]      AW_w_data,
  input  logic             AW_not_full,
  output logic             W_wr_en,
  output logic [36:0]      W_w_data,
  input  logic             W_not_full,
  output logic             B_rd_en,
  input  logic [9:0]       B_r_data,
  input  logic             B_not_empty
);

  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t        r_state;
  logic          r_gnt;
  logic          r_rr;
  logic [3:0]    r_len_q;
  logic [3:0]    r_beat;
  logic [CW-1:0] r_out_cnt;

  logic w_can_req;
  logic w_pick;
  logic w_aw_push;
  logic w_w_open;
  logic w_w_push;
  logic w_last;
  logic w_dst;
  logic w_b_pop;
  logic w_unused;

  assign w_can_req = (r_out_cnt < CW'(MAX_OUT)) & (|m_awvalid);
  assign w_pick    = (&m_awvalid) ? r_rr : m_awvalid[1];

  // Every push/pop is gated by rst so outputs drop the instant it rises.
  assign w_aw_push = ~rst & (r_state == S_ADDR) & AW_not_full;
  assign w_w_open  = ~rst & (r_state == S_DATA) & W_not_full;
  assign w_w_push  = w_w_open & m_wvalid[r_gnt];
  assign w_last    = (r_beat == r_len_q);

  assign w_dst   = B_r_data[6];
  assign w_b_pop = ~rst & B_not_empty & m_bready[w_dst];

  assign w_unused = ^B_r_data[9:7];

  assign AW_wr_en  = w_aw_push;
  assign AW_w_data = {
    3'b000,
    r_gnt,
    m_awid[r_gnt],
    m_awaddr[r_gnt],
    m_awlen[r_gnt],
    m_awsize[r_gnt],
    m_awburst[r_gnt]
  };

  assign W_wr_en  = w_w_push;
  assign W_w_data = {
    m_wdata[r_gnt],
    m_wstrb[r_gnt],
    w_last
  };

  assign B_rd_en = w_b_pop;
  assign m_bid   = B_r_data[5:2];
  assign m_bresp = B_r_data[1:0];

  always_comb begin
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_bvalid  = 2'b00;
    if (w_aw_push) begin
      m_awready[r_gnt] = 1'b1;
    end
    if (w_w_open) begin
      m_wready[r_gnt] = 1'b1;
    end
    if (~rst & B_not_empty) begin
      m_bvalid[w_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_rr    <= 1'b0;
      r_len_q <= 4'd0;
      r_beat  <= 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_can_req) begin
            r_gnt   <= w_pick;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_aw_push) begin
            r_len_q <= m_awlen[r_gnt];
            r_beat  <= 4'd0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_w_push) begin
            r_beat <= r_beat + 4'd1;
            if (w_last) begin
              r_rr    <= ~r_gnt;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A pop with nothing outstanding is a protocol error; clamp at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_cnt <= '0;
    end else if (w_aw_push & ~w_b_pop) begin
      if (r_out_cnt < CW'(MAX_OUT)) begin
        r_out_cnt <= r_out_cnt + 1'b1;
      end
    end else if (w_b_pop & ~w_aw_push) begin
      if (r_out_cnt != '0) begin
        r_out_cnt <= r_out_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_w_cdc_arbiter.sv
// Directed bench for w_cdc_arbiter with MAX_OUT = 2.
// Masters are modelled as simple hold-until-ready drivers.
module tb_w_cdc_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       m_awvalid;
  logic [1:0]       m_awready;
  logic [1:0][3:0]  m_awid;
  logic [1:0][31:0] m_awaddr;
  logic [1:0][3:0]  m_awlen;
  logic [1:0][2:0]  m_awsize;
  logic [1:0][1:0]  m_awburst;
  logic [1:0]       m_wvalid;
  logic [1:0]       m_wready;
  logic [1:0][31:0] m_wdata;
  logic [1:0][3:0]  m_wstrb;
  logic [1:0]       m_bvalid;
  logic [1:0]       m_bready;
  logic [3:0]       m_bid;
  logic [1:0]       m_bresp;
  logic             AW_wr_en;
  logic [48:0]      AW_w_data;
  logic             AW_not_full;
  logic             W_wr_en;
  logic [36:0]      W_w_data;
  logic             W_not_full;
  logic             B_rd_en;
  logic [9:0]       B_r_data;
  logic             B_not_empty;

  w_cdc_arbiter #(.MAX_OUT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .m_awid      (m_awid),
    .m_awaddr    (m_awaddr),
    .m_awlen     (m_awlen),
    .m_awsize    (m_awsize),
    .m_awburst   (m_awburst),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_bvalid    (m_bvalid),
    .m_bready    (m_bready),
    .m_bid       (m_bid),
    .m_bresp     (m_bresp),
    .AW_wr_en    (AW_wr_en),
    .AW_w_data   (AW_w_data),
    .AW_not_full (AW_not_full),
    .W_wr_en     (W_wr_en),
    .W_w_data    (W_w_data),
    .W_not_full  (W_not_full),
    .B_rd_en     (B_rd_en),
    .B_r_data    (B_r_data),
    .B_not_empty (B_not_empty)
  );

  int checks;
  int failures;
  int cyc;
  int viol;
  int areq[2];
  int wbeat[2];
  logic [1:0] acc_aw;
  logic [1:0] acc_w;

  logic [48:0] aw_data[$];
  int          aw_cyc[$];
  logic [36:0] w_data[$];
  int          w_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (AW_wr_en) begin
      aw_data.push_back(AW_w_data);
      aw_cyc.push_back(cyc);
    end
    if (W_wr_en) begin
      w_data.push_back(W_w_data);
      w_cyc.push_back(cyc);
    end
    if ((AW_wr_en && !AW_not_full) || (W_wr_en && !W_not_full)) begin
      viol = viol + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic half_neg();
    @(negedge clk);
    acc_aw = m_awready & m_awvalid;
    acc_w  = m_wready & m_wvalid;
  endtask

  task automatic half_pos();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc_w[i]) begin
        wbeat[i]   = wbeat[i] + 1;
        m_wdata[i] = 32'(256 * (i + 1) + wbeat[i]);
      end
      if (acc_aw[i]) begin
        areq[i]      = areq[i] - 1;
        m_awvalid[i] = (areq[i] != 0);
      end
    end
  endtask

  task automatic step();
    half_neg();
    half_pos();
  endtask

  task automatic clr_q();
    aw_data.delete();
    aw_cyc.delete();
    w_data.delete();
    w_cyc.delete();
  endtask

  task automatic idle_inputs();
    m_awvalid   = 2'b00;
    m_wvalid    = 2'b00;
    m_bready    = 2'b00;
    B_not_empty = 1'b0;
    B_r_data    = 10'd0;
    AW_not_full = 1'b1;
    W_not_full  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      areq[i]      = 0;
      wbeat[i]     = 0;
      m_awid[i]    = 4'd0;
      m_awaddr[i]  = 32'd0;
      m_awlen[i]   = 4'd0;
      m_awsize[i]  = 3'd2;
      m_awburst[i] = 2'd1;
      m_wdata[i]   = 32'(256 * (i + 1));
      m_wstrb[i]   = 4'hF;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clr_q();
  endtask

  function automatic logic [8:0] outs();
    return {m_awready, m_wready, m_bvalid, AW_wr_en, W_wr_en, B_rd_en};
  endfunction

  int n0;
  int p0;
  int q0;
  logic [3:0] lastv;

  initial begin
    checks   = 0;
    failures = 0;
    viol     = 0;
    acc_aw   = 2'b00;
    acc_w    = 2'b00;
    rst      = 1'b1;
    idle_inputs();

    // Reset: outputs forced low despite active inputs
    #2;
    m_awvalid   = 2'b11;
    m_wvalid    = 2'b11;
    m_bready    = 2'b11;
    B_not_empty = 1'b1;
    #1;
    chk("rst_outs", 64'(outs()), 64'd0);
    chk("rst_cnt", 64'(dut.r_out_cnt), 64'd0);

    // Test 1: single M0 burst, len 3, id 5
    do_reset();
    m_awid[0]   = 4'd5;
    m_awaddr[0] = 32'h1000;
    m_awlen[0]  = 4'd3;
    m_wvalid[0] = 1'b1;
    areq[0]     = 1;
    m_awvalid[0] = 1'b1;
    n0 = cyc;
    while (cyc < n0 + 6) step();
    chk("t1_idle", 64'(dut.r_state), 64'd0);
    chk("t1_aw_n", 64'(aw_data.size()), 64'd1);
    chk("t1_w_n", 64'(w_data.size()), 64'd4);
    if (aw_data.size() == 1 && w_data.size() == 4) begin
      chk("t1_aw_id", 64'(aw_data[0][48:41]), 64'h05);
      chk("t1_aw_all", 64'(aw_data[0]),
          64'({8'h05, 32'h1000, 4'd3, 3'd2, 2'd1}));
      chk("t1_aw_cyc", 64'(aw_cyc[0]), 64'(n0 + 1));
      chk("t1_w0_cyc", 64'(w_cyc[0]), 64'(n0 + 2));
      for (int k = 0; k < 4; k++) begin
        lastv[k] = w_data[k][0];
        chk("t1_wdata", 64'(w_data[k][36:1]),
            64'({32'(256 + k), 4'hF}));
      end
      chk("t1_last", 64'(lastv), 64'(4'b1000));
    end

    // Test 2: round-robin, len 0, B popped every cycle
    do_reset();
    m_awid[0]   = 4'hA;
    m_awid[1]   = 4'hB;
    m_wvalid    = 2'b11;
    m_bready    = 2'b01;
    B_not_empty = 1'b1;
    areq[0]     = 2;
    areq[1]     = 2;
    m_awvalid   = 2'b11;
    for (int t = 0; t < 30 && aw_data.size() < 4; t++) step();
    step();
    chk("t2_aw_n", 64'(aw_data.size()), 64'd4);
    if (aw_data.size() == 4 && w_data.size() >= 1) begin
      chk("t2_id0", 64'(aw_data[0][48:41]), 64'h0A);
      chk("t2_id1", 64'(aw_data[1][48:41]), 64'h1B);
      chk("t2_id2", 64'(aw_data[2][48:41]), 64'h0A);
      chk("t2_id3", 64'(aw_data[3][48:41]), 64'h1B);
      chk("t2_gap", 64'(aw_cyc[1] - w_cyc[0]), 64'd2);
    end

    // Test 3: AW stalled 3 cycles, then W_not_full toggles
    do_reset();
    m_awid[0]    = 4'd9;
    m_awlen[0]   = 4'd2;
    m_wvalid[0]  = 1'b1;
    areq[0]      = 1;
    m_awvalid[0] = 1'b1;
    n0 = cyc;
    repeat (14) begin
      AW_not_full = (cyc >= n0 + 4);
      W_not_full  = (cyc < n0 + 5) ? 1'b1 : ((cyc - n0) % 2 == 0);
      step();
    end
    AW_not_full = 1'b1;
    W_not_full  = 1'b1;
    chk("t3_aw_n", 64'(aw_data.size()), 64'd1);
    chk("t3_w_n", 64'(w_data.size()), 64'd3);
    if (aw_data.size() == 1 && w_data.size() == 3) begin
      chk("t3_aw_cyc", 64'(aw_cyc[0]), 64'(n0 + 4));
      lastv = 4'd0;
      for (int k = 0; k < 3; k++) begin
        lastv[k] = w_data[k][0];
        chk("t3_w_cyc", 64'(w_cyc[k]), 64'(n0 + 6 + 2 * k));
      end
      chk("t3_last", 64'(lastv), 64'(4'b0100));
    end

    // Test 4: cap of 2, third request stalls until a B pop
    do_reset();
    m_awid[0]    = 4'd1;
    m_wvalid[0]  = 1'b1;
    areq[0]      = 3;
    m_awvalid[0] = 1'b1;
    repeat (12) step();
    chk("t4_stall_n", 64'(aw_data.size()), 64'd2);
    chk("t4_bv_idle", 64'(m_bvalid), 64'd0);
    B_r_data    = {8'h13, 2'b00};
    B_not_empty = 1'b1;
    m_bready    = 2'b10;
    p0 = cyc;
    half_neg();
    chk("t4_bvalid", 64'(m_bvalid), 64'(2'b10));
    chk("t4_bid", 64'(m_bid), 64'd3);
    chk("t4_bresp", 64'(m_bresp), 64'd0);
    chk("t4_bpop", 64'(B_rd_en), 64'd1);
    half_pos();
    B_not_empty = 1'b0;
    repeat (6) step();
    chk("t4_aw_n", 64'(aw_data.size()), 64'd3);
    if (aw_data.size() == 3) begin
      chk("t4_grant_cyc", 64'(aw_cyc[2]), 64'(p0 + 2));
    end

    // Test 5a: AW push and B pop together leave the count alone
    m_awid[0]    = 4'd7;
    areq[0]      = 1;
    m_awvalid[0] = 1'b1;
    m_bready     = 2'b01;
    B_r_data     = {8'h00, 2'b01};
    repeat (2) step();
    chk("t5_stall_n", 64'(aw_data.size()), 64'd3);
    B_not_empty = 1'b1;
    q0 = cyc;
    half_neg();
    chk("t5_pop1", 64'(B_rd_en), 64'd1);
    half_pos();
    B_not_empty = 1'b0;
    chk("t5_cnt1", 64'(dut.r_out_cnt), 64'd1);
    step();
    B_not_empty = 1'b1;
    half_neg();
    chk("t5_sim", 64'({AW_wr_en, B_rd_en}), 64'(2'b11));
    half_pos();
    B_not_empty = 1'b0;
    chk("t5_cnt_hold", 64'(dut.r_out_cnt), 64'd1);
    chk("t5_sim_cyc", 64'(cyc), 64'(q0 + 3));

    // Test 5b: reset during DATA beat 2 of an M1 burst
    do_reset();
    m_awid[0]  = 4'd4;
    m_awid[1]  = 4'd2;
    m_awlen[1] = 4'd3;
    m_wvalid   = 2'b11;
    areq[0]    = 1;
    areq[1]    = 1;
    m_awvalid  = 2'b11;
    for (int t = 0; t < 30 && w_data.size() < 2; t++) step();
    chk("t5_pre_w", 64'(w_data.size()), 64'd2);
    chk("t5_pre_m1", 64'(aw_data.size() == 2 ? aw_data[1][48:41] : 8'hFF),
        64'h12);
    B_not_empty = 1'b1;
    m_bready    = 2'b11;
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", 64'(outs()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    clr_q();
    m_awid[0] = 4'd4;
    m_awid[1] = 4'd6;
    m_wvalid  = 2'b11;
    areq[0]   = 1;
    areq[1]   = 1;
    m_awvalid = 2'b11;
    rst = 1'b0;
    repeat (4) step();
    chk("t5_post_n", 64'(aw_data.size()), 64'd1);
    if (aw_data.size() >= 1) begin
      chk("t5_post_id", 64'(aw_data[0][48:41]), 64'h04);
    end

    chk("no_push_full", 64'(viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
